// File: rtl/fft_cfg_pkg.sv
// Shared constants, delay-profile helpers and config types for the FFT control skew block.
package fft_cfg_pkg;

    localparam int NUM_STAGE_DEF = 13;
    localparam int SCL_W_DEF     = 2;
    localparam int PROF_SYM      = 0;
    localparam int PROF_LIN      = 1;

    typedef logic [SCL_W_DEF-1:0] scl_t;

    typedef struct packed {
        logic [NUM_STAGE_DEF-1:0]           select;
        logic [SCL_W_DEF*NUM_STAGE_DEF-1:0] scaling;
    } cfg_t;

    // Pipeline depth seen by the first sample of a frame when it reaches stage i.
    function automatic int stage_delay(input int i, input int num_stage, input int profile);
        int fwd;
        int rev;
        fwd = i + 1;
        rev = num_stage - i;
        if (profile == PROF_LIN) begin
            return fwd;
        end
        return (fwd < rev) ? fwd : rev;
    endfunction

    function automatic int max_delay(input int num_stage, input int profile);
        int m;
        m = 1;
        for (int i = 0; i < num_stage; i++) begin
            if (stage_delay(i, num_stage, profile) > m) begin
                m = stage_delay(i, num_stage, profile);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fft_ctrl_skew_delay_line.sv
// Enable-gated shift register; the output is the DEPTH-th tap, so a value
// entered on one enabled cycle appears after DEPTH enabled cycles.
module ctrl_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] taps_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps_q[k] <= '0;
            end
        end else if (en_i) begin
            taps_q[0] <= din_i;
            for (int k = 1; k < DEPTH; k++) begin
                taps_q[k] <= taps_q[k-1];
            end
        end
    end

    assign dout_o = taps_q[DEPTH-1];

endmodule

// File: rtl/fft_ctrl_skew.sv
// Per-stage control skew for an SDF FFT: shadow/commit of a new config on a frame
// boundary, then per-stage delay so each butterfly switches with its first new sample.
// Optional zero-skew bypass input is enabled by defining FFT_CTRL_SKEW_BYPASS_EN.
module fft_ctrl_skew
    import fft_cfg_pkg::*;
#(
    parameter int NUM_STAGE = NUM_STAGE_DEF,
    parameter int SCL_W     = SCL_W_DEF,
    parameter int PROFILE   = PROF_SYM
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef FFT_CTRL_SKEW_BYPASS_EN
    input  logic                       bypass,
`endif
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [NUM_STAGE-1:0]       cfg_select,
    input  logic [SCL_W*NUM_STAGE-1:0] cfg_scaling,
    input  logic                       frame_start,
    input  logic                       adv,
    output logic [NUM_STAGE-1:0]       select_d,
    output logic [SCL_W*NUM_STAGE-1:0] scaling_d,
    output logic [NUM_STAGE-1:0]       stage_upd,
    output logic                       cfg_pending
);

    localparam int MAX_D = max_delay(NUM_STAGE, PROFILE);

    logic [NUM_STAGE-1:0]       shd_sel_q;
    logic [SCL_W*NUM_STAGE-1:0] shd_scl_q;
    logic [NUM_STAGE-1:0]       act_sel_q;
    logic [SCL_W*NUM_STAGE-1:0] act_scl_q;
    logic                       pending_q;
    logic [MAX_D-1:0]           tok_q;
    logic [NUM_STAGE-1:0]       stage_upd_q;
    logic [NUM_STAGE-1:0]       upd_d;
    logic [NUM_STAGE-1:0]       tap_sel;
    logic [SCL_W*NUM_STAGE-1:0] tap_scl;
    logic                       accept;
    logic                       commit;

    assign accept = cfg_valid & ~pending_q;
    assign commit = pending_q & frame_start & adv;

    // tok_q[j] marks a commit that has seen j advances since it was taken; all stages
    // advance together, so one shared token pipe serves every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_sel_q   <= '0;
            shd_scl_q   <= '0;
            act_sel_q   <= '0;
            act_scl_q   <= '0;
            pending_q   <= 1'b0;
            tok_q       <= '0;
            stage_upd_q <= '0;
        end else begin
            if (accept) begin
                shd_sel_q <= cfg_select;
                shd_scl_q <= cfg_scaling;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end

            if (commit) begin
                act_sel_q <= shd_sel_q;
                act_scl_q <= shd_scl_q;
            end

            if (commit) begin
                tok_q[0] <= 1'b1;
            end else if (adv) begin
                tok_q[0] <= 1'b0;
            end
            if (adv) begin
                for (int j = 1; j < MAX_D; j++) begin
                    tok_q[j] <= tok_q[j-1];
                end
            end

            stage_upd_q <= upd_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
            localparam int D = stage_delay(gi, NUM_STAGE, PROFILE);

            logic [SCL_W:0] line_in;
            logic [SCL_W:0] line_out;

            assign line_in = {act_sel_q[gi], act_scl_q[SCL_W*gi +: SCL_W]};

            ctrl_delay_line #(
                .WIDTH (SCL_W + 1),
                .DEPTH (D)
            ) u_line (
                .clk    (clk),
                .rst_n  (rst_n),
                .en_i   (adv),
                .din_i  (line_in),
                .dout_o (line_out)
            );

            assign tap_sel[gi]                  = line_out[SCL_W];
            assign tap_scl[SCL_W*gi +: SCL_W]   = line_out[SCL_W-1:0];
`ifdef FFT_CTRL_SKEW_BYPASS_EN
            assign upd_d[gi] = bypass ? commit : (adv & tok_q[D-1]);
`else
            // Token enters tap D on this advance; the pulse lines up with the new output.
            assign upd_d[gi] = adv & tok_q[D-1];
`endif
        end
    endgenerate

`ifdef FFT_CTRL_SKEW_BYPASS_EN
    assign select_d  = bypass ? act_sel_q : tap_sel;
    assign scaling_d = bypass ? act_scl_q : tap_scl;
`else
    assign select_d  = tap_sel;
    assign scaling_d = tap_scl;
`endif

    assign stage_upd   = stage_upd_q;
    assign cfg_pending = pending_q;
    assign cfg_ready   = ~pending_q;

endmodule

// File: tb/tb_fft_ctrl_skew.sv
// Self-checking bench for fft_ctrl_skew: directed scenarios plus random traffic
// against an advance-count model of when each stage sees each committed config.
module tb_fft_ctrl_skew;

    localparam int NS = 13;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            frame_start = 1'b0;
    logic            adv = 1'b0;
    logic [NS-1:0]   cfg_select = '0;
    logic [SW*NS-1:0] cfg_scaling = '0;
    logic            cfg_ready;
    logic            cfg_pending;
    logic [NS-1:0]   select_d;
    logic [SW*NS-1:0] scaling_d;
    logic [NS-1:0]   stage_upd;
`ifdef FFT_CTRL_SKEW_BYPASS_EN
    logic            bypass = 1'b0;
`endif

    always #5 clk = ~clk;

    fft_ctrl_skew dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef FFT_CTRL_SKEW_BYPASS_EN
        .bypass      (bypass),
`endif
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_select  (cfg_select),
        .cfg_scaling (cfg_scaling),
        .frame_start (frame_start),
        .adv         (adv),
        .select_d    (select_d),
        .scaling_d   (scaling_d),
        .stage_upd   (stage_upd),
        .cfg_pending (cfg_pending)
    );

    // Model: each commit is stamped with the advance count that included it.
    typedef struct {
        int               n;
        logic [NS-1:0]    sel;
        logic [SW*NS-1:0] scl;
    } commit_t;

    commit_t          hist[$];
    int               adv_cnt = 0;
    bit               m_pending = 1'b0;
    bit               m_last_adv = 1'b0;
    logic [NS-1:0]    m_shd_sel = '0;
    logic [SW*NS-1:0] m_shd_scl = '0;
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bdelay(input int i);
        int a;
        int b;
        a = i + 1;
        b = NS - i;
        return (a < b) ? a : b;
    endfunction

    task automatic check_all();
        logic [NS-1:0]    es;
        logic [NS-1:0]    eu;
        logic [SW*NS-1:0] ec;
        es = '0;
        eu = '0;
        ec = '0;
        for (int i = 0; i < NS; i++) begin
            int d;
            d = bdelay(i);
            foreach (hist[k]) begin
                if (hist[k].n + d <= adv_cnt) begin
                    es[i]         = hist[k].sel[i];
                    ec[i*SW +: SW] = hist[k].scl[i*SW +: SW];
                end
                if (m_last_adv && (hist[k].n + d == adv_cnt)) begin
                    eu[i] = 1'b1;
                end
            end
        end
        chk("cfg_ready",   32'(cfg_ready),   32'(!m_pending));
        chk("cfg_pending", 32'(cfg_pending), 32'(m_pending));
        chk("select_d",    32'(select_d),    32'(es));
        chk("scaling_d",   32'(scaling_d),   32'(ec));
        chk("stage_upd",   32'(stage_upd),   32'(eu));
    endtask

    // One clock: drive inputs, let the edge happen, update the model, check on negedge.
    task automatic cyc(input logic v, input logic fs, input logic a,
                       input logic [NS-1:0] sel, input logic [SW*NS-1:0] scl);
        bit acc;
        bit com;
        cfg_valid   = v;
        frame_start = fs;
        adv         = a;
        cfg_select  = sel;
        cfg_scaling = scl;
        acc = v && !m_pending;
        com = m_pending && fs && a;
        @(posedge clk);
        if (a) adv_cnt++;
        if (acc) begin
            m_shd_sel = sel;
            m_shd_scl = scl;
            m_pending = 1'b1;
        end else if (com) begin
            commit_t c;
            c.n   = adv_cnt;
            c.sel = m_shd_sel;
            c.scl = m_shd_scl;
            hist.push_back(c);
            m_pending = 1'b0;
            $display("commit at adv %0d sel=%h scl=%h", adv_cnt, m_shd_sel, m_shd_scl);
        end
        m_last_adv = a;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        cfg_valid   = 1'b0;
        frame_start = 1'b0;
        adv         = 1'b0;
        rst_n       = 1'b0;
        #1;
        hist.delete();
        m_pending  = 1'b0;
        m_last_adv = 1'b0;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        int t6;
        int t12;
        int cnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Basic latency with adv held high.
        cyc(1, 0, 1, 13'h1555, 26'h2AAAAAA);
        cyc(0, 1, 1, '0, '0);
        t0 = -1; t6 = -1; t12 = -1;
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 1, '0, '0);
            if (stage_upd[0]  && t0  < 0) t0  = k;
            if (stage_upd[6]  && t6  < 0) t6  = k;
            if (stage_upd[12] && t12 < 0) t12 = k;
        end
        chk("lat_s0", t0, 1);
        chk("lat_s12", t12, 1);
        chk("lat_s6", t6, 7);

        // Three stall cycles starting two cycles after commit.
        cyc(1, 0, 1, 13'h0AAA, 26'h1555555);
        cyc(0, 1, 1, '0, '0);
        t6 = -1;
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 0, (k >= 2 && k <= 4) ? 1'b0 : 1'b1, '0, '0);
            if (stage_upd[6] && t6 < 0) t6 = k;
        end
        chk("lat_s6_stall", t6, 10);

        // Second config offered while the first is pending.
        cyc(1, 0, 1, 13'h0F0F, 26'h0000000);
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 13'h00F0, 26'h3FFFFFF);
        cyc(1, 1, 1, 13'h00F0, 26'h3FFFFFF);
        cyc(1, 0, 1, 13'h00F0, 26'h3FFFFFF);
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, '0, '0);
        cyc(0, 1, 1, '0, '0);
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, '0, '0);

        // frame_start with nothing pending, then frame_start during a stall.
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, '0, '0);
        cyc(1, 0, 1, 13'h1000, 26'h3000000);
        cyc(0, 1, 0, '0, '0);
        cyc(0, 1, 0, '0, '0);
        chk("pend_hold", 32'(cfg_pending), 32'd1);
        cyc(0, 1, 1, '0, '0);
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, '0, '0);

        // Commits 16 advances apart: stage 6 must show A for exactly 16 samples.
        cnt = 0;
        cyc(1, 0, 1, 13'h1FFF, 26'h1555555);
        cyc(0, 1, 1, '0, '0);
        cyc(1, 0, 1, 13'h0000, 26'h3FFFFFF);
        if (select_d[6] && scaling_d[13:12] == 2'b01) cnt++;
        for (int k = 2; k <= 15; k++) begin
            cyc(0, 0, 1, '0, '0);
            if (select_d[6] && scaling_d[13:12] == 2'b01) cnt++;
        end
        cyc(0, 1, 1, '0, '0);
        if (select_d[6] && scaling_d[13:12] == 2'b01) cnt++;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 1, '0, '0);
            if (select_d[6] && scaling_d[13:12] == 2'b01) cnt++;
        end
        chk("hold_A_s6", cnt, 16);

        // Reset while five stages are still skewing.
        cyc(1, 0, 1, 13'h1FFF, 26'h3FFFFFF);
        cyc(0, 1, 1, '0, '0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, '0, '0);
        do_reset();
        for (int k = 0; k < 10; k++) cyc(0, 0, 1, '0, '0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) != 0), NS'($urandom), (SW*NS)'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_ctrl_skew.md
Name: fft_ctrl_skew

Overview:
Parametrised per-stage control skew pipeline for the pipelined (SDF) FFT datapath. It accepts a new transform configuration (per-stage select bit and per-stage scaling field) through a valid/ready handshake into a one-deep shadow register. The configuration is committed only on a frame boundary. Each stage's field is then delayed by that stage's own pipeline depth, so every butterfly stage switches configuration exactly when the first sample of the new frame reaches it. Delay lines advance only on datapath advance, so datapath stalls keep the control aligned with the data.

Parameters:
NUM_STAGE, 13, number of butterfly stages (log2 of max FFT points)
SCL_W, 2, scaling field width per stage
PROFILE, 0, delay profile: 0 = symmetric, D(i)=min(i+1, NUM_STAGE-i); 1 = linear, D(i)=i+1
MAX_D, derived, maximum D(i) over all stages; sizes the delay lines

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  shadow register free
cfg_select  in  NUM_STAGE  per-stage select bits; bit i belongs to stage i
cfg_scaling  in  SCL_W*NUM_STAGE  per-stage scaling; stage i occupies [SCL_W*i +: SCL_W]
frame_start  in  1  first sample of a frame enters the datapath on this cycle
adv  in  1  datapath advance enable (0 = stall)
select_d  out  NUM_STAGE  skewed select bits
scaling_d  out  SCL_W*NUM_STAGE  skewed scaling fields
stage_upd  out  NUM_STAGE  one-cycle pulse: stage i has just received a newly committed field
cfg_pending  out  1  shadow holds an uncommitted configuration

Behaviour:
- Reset (async, rst_n=0) clears all of the following: shadow, active register, every delay-line tap, token pipes, select_d, scaling_d, stage_upd and cfg_pending. cfg_ready is 1 after reset.
- Handshake: accept occurs when cfg_valid && cfg_ready, and the shadow captures cfg_select/cfg_scaling. Then cfg_pending=1 and cfg_ready=0 from the next cycle. cfg_ready equals !cfg_pending (registered, no combinational path from cfg_valid).
- Commit occurs when cfg_pending && frame_start && adv. The active register loads the shadow, a commit token enters every stage's token pipe, and cfg_pending clears next cycle.
  - Accept and commit cannot coincide, because ready is low while pending.
  - frame_start without pending: the active config is unchanged and no token is issued.
- Per-stage delay line i is D(i) registers deep, with the active field as input. It shifts only when adv=1 and holds otherwise. select_d[i]/scaling_d[i] are the last tap. Example: NUM_STAGE=13, symmetric profile gives delays 1,2,3,4,5,6,7,6,5,4,3,2,1.
- Latency: stage i output changes on the D(i)-th adv=1 cycle after the commit cycle. Stall cycles add no advance.
- stage_upd[i] is high for exactly one clock when the token reaches tap D(i) on an adv=1 cycle. It is 0 on stalls.
- Back-to-back commits on consecutive frames are legal. Each stage sees each config for exactly the number of advances between commits.
- adv=0 on a frame_start cycle: no commit; the request stays pending.
- Mid-operation reset: everything clears immediately. In-flight configs are lost and outputs return to 0.

Optional Feature:
- Macro: FFT_CTRL_SKEW_BYPASS_EN.
- When defined: adds input port bypass (1 bit).
  - bypass=1 drives select_d/scaling_d directly from the active register (zero skew) and pulses stage_upd on all stages in the cycle after commit.
  - Delay lines continue to shift underneath.
  - When bypass is deasserted, outputs revert to the taps.
- When not defined: no port and no mux; behaviour is as above.

Decomposition:
- Package fft_cfg_pkg:
  - constants for NUM_STAGE default, SCL_W default and PROFILE encodings (PROF_SYM=0, PROF_LIN=1);
  - automatic function stage_delay(i, num_stage, profile);
  - function max_delay;
  - typedefs for the per-stage scaling field and config struct {select, scaling}.
- Sub-module ctrl_delay_line:
  - parameters WIDTH, DEPTH;
  - enable-gated shift register with async active-low reset;
  - instantiated per stage in a generate loop, once for data (1+SCL_W bits) and once for the 1-bit token, or merged as WIDTH=2+SCL_W.

Test Plan:
- Reset, then accept select=13'h1555, scaling all 2'b10, commit with adv held 1. Stage 0 and stage 12 outputs change after 1 cycle; stage 6 after 7 cycles. stage_upd pulses once per stage at those cycles.
- Same as above but adv=0 for 3 cycles starting 2 cycles after commit. Stage 6 update moves from cycle 7 to cycle 10 and outputs hold during the stall.
- Offer second cfg while pending. cfg_ready=0, no capture, cfg_valid holds. Accepted cycle after commit; shadow content verified at next commit.
- frame_start pulses with no pending config. Outputs and stage_upd are unchanged; frame_start with adv=0 leaves cfg_pending=1.
- Commits 16 advances apart, configs A then B. Every stage shows A for exactly 16 advances before B.
- Assert rst_n=0 for 1 cycle while 5 stages are still skewing. All outputs are 0 immediately, cfg_ready=1, and no stale stage_upd after release.
